// File: rtl/halflife_pkg.sv
// halflife_pkg: shared state encoding, default widths and period substitution for the half-life decay controller
package halflife_pkg;
    localparam int N_DEF  = 4;
    localparam int PW_DEF = 8;
    localparam int EW_DEF = 4;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DECAY, S_DONE} hl_state_t;
    function automatic int period_cycles(input int p, input int pw);
        return (p == 0) ? (1 << pw) : p;
    endfunction
endpackage

// File: rtl/hl_epoch_timer.sv
// hl_epoch_timer: epoch tick counter; ports clk, rst (active-low sync), clr, en, period_eff -> tick, at_end (tick reached period_eff-1 or beyond)
module hl_epoch_timer #(
    parameter int PW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [PW:0] period_eff,
    output logic [PW:0] tick,
    output logic        at_end
);
    always_ff @(posedge clk)
        if (!rst) tick <= '0;
        else tick <= clr ? '0 : en ? tick + 1'b1 : tick;
    // >= rather than == lets an epoch stretch past the period while pulses remain
    assign at_end = tick >= period_eff - 1'b1;
endmodule

// File: rtl/halflife_decay_ctrl.sv
// halflife_decay_ctrl: drives a half-life down-counter; ports clk, rst (active-low sync), start, abort, init, period -> cnt_load, cnt_val, cnt_dec, remaining, epochs, busy, done
module halflife_decay_ctrl
    import halflife_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int PW = PW_DEF,
    parameter int EW = EW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  init,
    input  logic [PW-1:0] period,
    output logic          cnt_load,
    output logic [N-1:0]  cnt_val,
    output logic          cnt_dec,
    output logic [N-1:0]  remaining,
    output logic [EW-1:0] epochs,
    output logic          busy,
    output logic          done
);
    hl_state_t    state;
    logic [N-1:0] init_q, dec_left, dec_next, rem_next;
    logic [PW:0]  per_q, tick;
    logic         at_end, epoch_end, go;
    assign cnt_load  = state == S_LOAD;
    assign cnt_dec   = state == S_DECAY && dec_left != '0;
    assign cnt_val   = state == S_IDLE ? '0 : init_q;
    assign busy      = state == S_LOAD || state == S_DECAY;
    assign done      = state == S_DONE;
    assign dec_next  = dec_left - N'(cnt_dec);
    assign rem_next  = remaining - N'(cnt_dec);
    assign epoch_end = state == S_DECAY && at_end && dec_next == '0;
    assign go        = start && !abort && (state == S_IDLE || state == S_DONE);
    hl_epoch_timer #(.PW(PW)) u_timer (
        .clk(clk), .rst(rst), .clr(cnt_load || epoch_end), .en(state == S_DECAY),
        .period_eff(per_q), .tick(tick), .at_end(at_end)
    );
    // remaining mirrors the counter, so a strobe already on the wire is tracked even on an abort cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            init_q    <= '0;
            per_q     <= '0;
            dec_left  <= '0;
            remaining <= '0;
            epochs    <= '0;
        end else begin
            if (go) begin
                init_q <= init;
                per_q  <= (PW+1)'(period_cycles(int'(period), PW));
            end
            if (cnt_load) begin
                remaining <= init_q;
                epochs    <= '0;
                dec_left  <= init_q >> 1;
            end else if (cnt_dec) begin
                remaining <= rem_next;
                dec_left  <= dec_next;
            end
            if (epoch_end) begin
                epochs   <= epochs == '1 ? epochs : epochs + 1'b1;
                dec_left <= rem_next >> 1;
            end
            state <= abort && state != S_IDLE ? S_IDLE :
                     go ? S_LOAD :
                     cnt_load ? (init_q <= N'(1) ? S_DONE : S_DECAY) :
                     epoch_end && rem_next <= N'(1) ? S_DONE : state;
        end
    end
endmodule

// File: tb/tb_halflife_decay_ctrl.sv
// tb_halflife_decay_ctrl: directed and randomized checks of halflife_decay_ctrl against an epoch-level reference model
module tb_halflife_decay_ctrl;
    logic       clk = 0, rst = 0, start = 0, abort = 0;
    logic [3:0] init = 0;
    logic [7:0] period = 0;
    logic       cnt_load, cnt_dec, busy, done;
    logic [3:0] cnt_val, remaining, epochs;
    int checks = 0, errors = 0;
    int exp_dec [0:1199];
    int exp_rem [0:1199];
    int exp_ep  [0:1199];

    halflife_decay_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .init(init), .period(period),
        .cnt_load(cnt_load), .cnt_val(cnt_val), .cnt_dec(cnt_dec), .remaining(remaining),
        .epochs(epochs), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // epoch-level model: each epoch spends max(period, r/2) cycles, pulses first
    task automatic build(input int ini, input int pe, output int dc);
        int c, r, e, k, len;
        for (int i = 0; i < 1200; i++) begin
            exp_dec[i] = 0; exp_rem[i] = 0; exp_ep[i] = 0;
        end
        c = 2; r = ini; e = 0;
        while (r > 1) begin
            k = r / 2;
            len = pe > k ? pe : k;
            for (int i = 0; i < len; i++) begin
                exp_dec[c+i] = (i < k) ? 1 : 0;
                exp_rem[c+i] = r - ((i < k) ? i : k);
                exp_ep[c+i]  = e;
            end
            r = r - k;
            e = (e < 15) ? e + 1 : e;
            c = c + len;
        end
        dc = c;
        exp_rem[c] = r;
        exp_ep[c]  = e;
    endtask

    task automatic launch(input int ini, input int p);
        @(negedge clk);
        init = 4'(ini); period = 8'(p); start = 1; abort = 0;
    endtask

    task automatic test_reset;
        rst = 0; start = 1; init = 4'd9; period = 8'd3;
        repeat (3) @(negedge clk);
        checks++;
        if ({cnt_load, cnt_val, cnt_dec, remaining, epochs, busy, done} !== 15'd0) begin
            errors++;
            $display("FAIL reset: outputs=%h required 0", {cnt_load, cnt_val, cnt_dec, remaining, epochs, busy, done});
        end
        start = 0; rst = 1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [31:0] dmask;
        dmask = 32'h0000_04FC;
        launch(8, 4);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = 0;
            checks += 3;
            if (cnt_load !== (c == 1)) begin errors++; $display("FAIL basic load c%0d: got %b", c, cnt_load); end
            if (cnt_dec !== dmask[c]) begin errors++; $display("FAIL basic dec c%0d: got %b want %b", c, cnt_dec, dmask[c]); end
            if (done !== (c == 14)) begin errors++; $display("FAIL basic done c%0d: got %b", c, done); end
            if (c == 1) begin
                checks++;
                if (cnt_val !== 4'd8) begin errors++; $display("FAIL basic cnt_val: got %0d want 8", cnt_val); end
            end
            if (c == 6 || c == 10 || c == 14) begin
                checks++;
                if (remaining !== 4'(c == 6 ? 4 : c == 10 ? 2 : 1)) begin errors++; $display("FAIL basic remaining c%0d: got %0d", c, remaining); end
            end
        end
        checks++;
        if (epochs !== 4'd3) begin errors++; $display("FAIL basic epochs: got %0d want 3", epochs); end
    endtask

    task automatic test_init_one;
        launch(1, 5);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 0;
            checks += 3;
            if (cnt_load !== (c == 1)) begin errors++; $display("FAIL one load c%0d: got %b", c, cnt_load); end
            if (cnt_dec !== 1'b0) begin errors++; $display("FAIL one dec c%0d: got %b want 0", c, cnt_dec); end
            if (done !== (c >= 2)) begin errors++; $display("FAIL one done c%0d: got %b", c, done); end
        end
        checks++;
        if (epochs !== 4'd0 || remaining !== 4'd1) begin errors++; $display("FAIL one final: epochs=%0d remaining=%0d want 0,1", epochs, remaining); end
    endtask

    task automatic test_stretch;
        launch(15, 2);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            start = 0;
            checks += 2;
            if (cnt_dec !== (c >= 2 && c <= 15)) begin errors++; $display("FAIL stretch dec c%0d: got %b", c, cnt_dec); end
            if (done !== (c == 17)) begin errors++; $display("FAIL stretch done c%0d: got %b", c, done); end
            if (c == 9 || c == 13 || c == 15 || c == 17) begin
                checks++;
                if (remaining !== 4'(c == 9 ? 8 : c == 13 ? 4 : c == 15 ? 2 : 1)) begin errors++; $display("FAIL stretch remaining c%0d: got %0d", c, remaining); end
            end
        end
        checks++;
        if (epochs !== 4'd4) begin errors++; $display("FAIL stretch epochs: got %0d want 4", epochs); end
    endtask

    task automatic test_period_zero;
        int ndec = 0;
        launch(2, 0);
        for (int c = 1; c <= 258; c++) begin
            @(negedge clk);
            start = 0;
            if (cnt_dec === 1'b1) ndec++;
            if (c == 2 || c == 257 || c == 258) begin
                checks++;
                if (done !== (c == 258) || (c == 2 && cnt_dec !== 1'b1)) begin
                    errors++; $display("FAIL pzero c%0d: done=%b dec=%b", c, done, cnt_dec);
                end
            end
        end
        checks++;
        if (ndec != 1 || epochs !== 4'd1) begin errors++; $display("FAIL pzero totals: decs=%0d epochs=%0d want 1,1", ndec, epochs); end
    endtask

    task automatic test_abort;
        launch(8, 4);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 0;
        end
        abort = 1; start = 1; init = 4'd12;
        @(negedge clk);
        abort = 0; start = 0;
        checks++;
        if ({cnt_load, cnt_dec, busy, done} !== 4'b0 || remaining !== 4'd6 || cnt_val !== 4'd0) begin
            errors++; $display("FAIL abort c4: load=%b dec=%b busy=%b done=%b rem=%0d val=%0d want 0,0,0,0,6,0", cnt_load, cnt_dec, busy, done, remaining, cnt_val);
        end
        for (int c = 5; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if ({cnt_load, cnt_dec, busy} !== 3'b0 || remaining !== 4'd6) begin errors++; $display("FAIL abort idle c%0d: load=%b dec=%b busy=%b rem=%0d", c, cnt_load, cnt_dec, busy, remaining); end
        end
    endtask

    task automatic test_reset_mid;
        int ndec = 0;
        launch(8, 4);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 0;
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if ({cnt_load, cnt_val, cnt_dec, remaining, epochs, busy, done} !== 15'd0) begin
            errors++; $display("FAIL rstmid: outputs=%h required 0", {cnt_load, cnt_val, cnt_dec, remaining, epochs, busy, done});
        end
        rst = 1;
        launch(3, 1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 0;
            if (cnt_dec === 1'b1) ndec++;
            checks++;
            if (done !== (c == 4)) begin errors++; $display("FAIL rstmid done c%0d: got %b", c, done); end
        end
        checks++;
        if (ndec != 2 || epochs !== 4'd2 || remaining !== 4'd1) begin
            errors++; $display("FAIL rstmid rerun: decs=%0d epochs=%0d rem=%0d want 2,2,1", ndec, epochs, remaining);
        end
    endtask

    task automatic test_random;
        int ini, p, dc;
        for (int run = 0; run < 24; run++) begin
            ini = $urandom_range(0, 15);
            p = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 6);
            build(ini, p == 0 ? 256 : p, dc);
            launch(ini, p);
            for (int c = 1; c <= dc; c++) begin
                @(negedge clk);
                checks += 5;
                if (cnt_load !== (c == 1)) begin errors++; $display("FAIL rnd%0d load c%0d: got %b", run, c, cnt_load); end
                if (cnt_dec !== 1'(exp_dec[c])) begin errors++; $display("FAIL rnd%0d dec c%0d: got %b want %0d", run, c, cnt_dec, exp_dec[c]); end
                if (done !== (c == dc) || busy !== (c < dc)) begin errors++; $display("FAIL rnd%0d status c%0d: done=%b busy=%b", run, c, done, busy); end
                if (cnt_val !== 4'(ini)) begin errors++; $display("FAIL rnd%0d cnt_val c%0d: got %0d want %0d", run, c, cnt_val, ini); end
                if (c >= 2 && (remaining !== 4'(exp_rem[c]) || epochs !== 4'(exp_ep[c]))) begin
                    errors++; $display("FAIL rnd%0d state c%0d: rem=%0d ep=%0d want %0d,%0d", run, c, remaining, epochs, exp_rem[c], exp_ep[c]);
                end
                start = (c < dc) ? 1'($urandom) : 1'b0;
                init = 4'($urandom);
                period = 8'($urandom);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_init_one;
        test_stretch;
        test_period_zero;
        test_abort;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
